game_state_controller: RTL and testbench
========================================

# game_state_controller

Top-level game sequencer that consumes the latched per-player death flags from the hazard (water/lava/goo) collision blocks and the per-player door-reached flags. It runs the IDLE → PLAY → DYING/WIN → GAMEOVER flow and issues a one-cycle `level_reset` pulse that clears the hazard latches and re-spawns the players. It also drives a freeze signal for the player movement blocks and a state code and blink bit for the renderer.

## Interface
Parameters:
- `DEATH_FRAMES`, default 60: frame ticks spent in DYING before GAMEOVER.
- `GAMEOVER_FRAMES`, default 180: frame ticks in GAMEOVER before auto-return to IDLE.
- `WIN_FRAMES`, default 120: frame ticks in WIN before return to IDLE.
- Constraint: all three parameters are ≤ 255.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: Reset Reset, synchronous, active-high; clock Clk.
- `frame_clk`, in, 1: VGA vsync, asynchronous to the FSM. Its rising edge is one frame.
- `start_key`, in, 1: level from the keyboard decoder (Enter held).
- `player1_dead`, in, 1: latched death flag from the hazard blocks, OR-reduced.
- `player2_dead`, in, 1: latched death flag from the hazard blocks, OR-reduced.
- `player1_at_door`, in, 1: player 1 overlaps its exit door.
- `player2_at_door`, in, 1: player 2 overlaps its exit door.
- `level_reset`, out, 1: one-cycle pulse. Fanned out to hazard, player and door Reset inputs, ORed with `Reset` at top level.
- `players_frozen`, out, 1: high whenever state ≠ PLAY.
- `game_state`, out, 3: current state encoding.
- `dead_player`, out, 2: {p2, p1}, captured at death.
- `blink`, out, 1: flash bit for the death overlay.

## Operation
- Frame tick: `frame_clk` passes through a 2-flop synchronizer, then rising-edge detect. The result is `frame_tick`, one `Clk` cycle wide.
- Start edge: `start_edge` = `start_key` & ~`start_key_q`, where `start_key_q` is a registered copy. Holding the key produces exactly one edge.
- `frame_cnt`: 8 bits. Cleared on every state entry. Increments on `frame_tick` in DYING, GAMEOVER and WIN. Never wraps, because exit occurs at the parameter value.
- IDLE:
  - `start_edge` → PLAY, with `level_reset` = 1.
- PLAY:
  - If `level_reset` is high this cycle, dead and door inputs are ignored. They are stale until the hazards clear.
  - Otherwise, (`player1_dead` | `player2_dead`) → DYING, and `dead_player` ← {`player2_dead`, `player1_dead`}.
  - Otherwise, (`player1_at_door` & `player2_at_door`) → WIN.
  - Death has priority over win in the same cycle.
- DYING:
  - `blink` = `frame_cnt[3]`.
  - `frame_cnt` == `DEATH_FRAMES` → GAMEOVER.
  - `start_edge` is ignored.
- GAMEOVER:
  - `start_edge` → PLAY, with `level_reset` = 1 and `dead_player` ← 0.
  - Otherwise, `frame_cnt` == `GAMEOVER_FRAMES` → IDLE.
  - Start has priority over timeout in the same cycle.
- WIN:
  - `frame_cnt` == `WIN_FRAMES` → IDLE.
  - `start_edge` is ignored.
- `blink` is 0 outside DYING.
- `dead_player` holds its value through GAMEOVER. It is cleared on entry to PLAY and on entry to IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `game_state` = IDLE
  - `level_reset` = 0
  - `players_frozen` = 1
  - `dead_player` = 0
  - `blink` = 0
  - `frame_cnt` = 0
  - synchronizer and edge registers = 0
- Start latency: `start_key` rises before edge N. Then `start_edge` = 1 in cycle N. At N+1, state = PLAY, `level_reset` = 1 and `players_frozen` = 0. At N+2, `level_reset` = 0.
- Death latency: a dead input is high in cycle M (PLAY, `level_reset` = 0). At M+1, state = DYING, `players_frozen` = 1 and `dead_player` is valid.
- Frame tick lag: 3 `Clk` cycles after the `frame_clk` rising edge (2 sync flops + edge register).
- Timed exit: the transition occurs on the clock after the tick that makes `frame_cnt` reach its limit. Dwell time is exactly N ticks.
- Reset mid-operation: takes effect on the next edge from any state. No `level_reset` pulse is issued; the top level ORs `Reset` into the downstream resets.

## Structure
- Package `game_pkg`:
  - `typedef enum logic [2:0] game_state_t` with IDLE = 0, PLAY = 1, DYING = 2, GAMEOVER = 3, WIN = 4.
  - Default frame constants.
  - Shared by the renderer and this block.
- Sub-module `frame_tick_gen`: the 2-flop synchronizer plus rising-edge detect, producing `frame_tick`. It is reusable by animation blocks.

## Test plan
- Reset, then pulse `start_key` → exactly one `level_reset` cycle, `game_state` = 1, `players_frozen` = 0. Holding the key gives no second pulse.
- PLAY, assert `player2_dead` only → `game_state` = 2 next cycle, `dead_player` = 2'b10. `blink` toggles every 8 ticks. After 60 ticks, `game_state` = 3.
- PLAY, `player1_dead` and both door flags in the same cycle → DYING, not WIN, `dead_player` = 2'b01.
- Both door flags in PLAY → WIN. Start presses are ignored. After 120 ticks, IDLE with `players_frozen` = 1.
- GAMEOVER with start edge in the same cycle as the 180th tick → PLAY plus `level_reset`. A stale `player1_dead` = 1 during the pulse cycle does not re-enter DYING.
- Assert `Reset` during DYING at tick 30 → next cycle all outputs equal their reset values and `frame_cnt` = 0.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encoding and default frame timing constants
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    GAMEOVER = 3'd3,
    WIN      = 3'd4
  } game_state_t;

  localparam int DEF_DEATH_FRAMES    = 60;
  localparam int DEF_GAMEOVER_FRAMES = 180;
  localparam int DEF_WIN_FRAMES      = 120;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - synchronizes asynchronous vsync and emits a one-cycle tick per rising edge
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q, edge_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  assign frame_tick = sync2_q & ~edge_q;

endmodule

// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - IDLE/PLAY/DYING/WIN/GAMEOVER sequencer with level reset pulse
module game_state_controller
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES    = DEF_DEATH_FRAMES,
  parameter int GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
  parameter int WIN_FRAMES      = DEF_WIN_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  output logic       level_reset,
  output logic       players_frozen,
  output logic [2:0] game_state,
  output logic [1:0] dead_player,
  output logic       blink
);

  localparam logic [7:0] DEATH_LIM    = 8'(DEATH_FRAMES);
  localparam logic [7:0] GAMEOVER_LIM = 8'(GAMEOVER_FRAMES);
  localparam logic [7:0] WIN_LIM      = 8'(WIN_FRAMES);

  game_state_t state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        level_reset_q, level_reset_d;
  logic        frozen_q, frozen_d;
  logic [1:0]  dead_player_q, dead_player_d;
  logic        blink_q, blink_d;
  logic        start_key_q, start_key_d;
  logic        frame_tick;
  logic        start_edge;

  frame_tick_gen u_frame_tick_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  assign start_edge = start_key & ~start_key_q;

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    level_reset_d = 1'b0;
    dead_player_d = dead_player_q;
    start_key_d   = start_key;

    if (frame_tick && (state_q == DYING || state_q == GAMEOVER || state_q == WIN))
      frame_cnt_d = frame_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d       = PLAY;
          level_reset_d = 1'b1;
        end
      end
      PLAY: begin
        // Hazard latches still hold old deaths while the reset pulse is in flight.
        if (!level_reset_q) begin
          if (player1_dead || player2_dead) begin
            state_d       = DYING;
            dead_player_d = {player2_dead, player1_dead};
          end else if (player1_at_door && player2_at_door) begin
            state_d = WIN;
          end
        end
      end
      DYING: begin
        if (frame_cnt_q == DEATH_LIM) state_d = GAMEOVER;
      end
      GAMEOVER: begin
        if (start_edge) begin
          state_d       = PLAY;
          level_reset_d = 1'b1;
          dead_player_d = 2'b00;
        end else if (frame_cnt_q == GAMEOVER_LIM) begin
          state_d       = IDLE;
          dead_player_d = 2'b00;
        end
      end
      WIN: begin
        if (frame_cnt_q == WIN_LIM) begin
          state_d       = IDLE;
          dead_player_d = 2'b00;
        end
      end
      default: begin
        state_d       = IDLE;
        dead_player_d = 2'b00;
      end
    endcase

    if (state_d != state_q) frame_cnt_d = 8'd0;

    frozen_d = (state_d != PLAY);
    blink_d  = (state_d == DYING) & frame_cnt_d[3];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= 8'd0;
      level_reset_q <= 1'b0;
      frozen_q      <= 1'b1;
      dead_player_q <= 2'b00;
      blink_q       <= 1'b0;
      start_key_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      level_reset_q <= level_reset_d;
      frozen_q      <= frozen_d;
      dead_player_q <= dead_player_d;
      blink_q       <= blink_d;
      start_key_q   <= start_key_d;
    end
  end

  assign level_reset    = level_reset_q;
  assign players_frozen = frozen_q;
  assign game_state     = state_q;
  assign dead_player    = dead_player_q;
  assign blink          = blink_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - directed scoreboard bench for game_state_controller
module tb_game_state_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start_key = 1'b0;
  logic       player1_dead = 1'b0;
  logic       player2_dead = 1'b0;
  logic       player1_at_door = 1'b0;
  logic       player2_at_door = 1'b0;
  logic       level_reset;
  logic       players_frozen;
  logic [2:0] game_state;
  logic [1:0] dead_player;
  logic       blink;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_DYING = 3'd2,
                         S_GAMEOVER = 3'd3, S_WIN = 3'd4;

  game_state_controller dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .start_key      (start_key),
    .player1_dead   (player1_dead),
    .player2_dead   (player2_dead),
    .player1_at_door(player1_at_door),
    .player2_at_door(player2_at_door),
    .level_reset    (level_reset),
    .players_frozen (players_frozen),
    .game_state     (game_state),
    .dead_player    (dead_player),
    .blink          (blink)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Each pulse fully propagates through the synchronizer before the task returns.
  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step(4);
      frame_clk = 1'b0;
      step(4);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic lr,
                            input logic fz, input logic [1:0] dp, input logic bl);
    exp_q.push_back({st, lr, fz, dp, bl});
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [7:0] obs;
    logic [7:0] e;
    string      t;
    obs = {game_state, level_reset, players_frozen, dead_player, blink};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed {st,lr,fz,dp,bl}=%b required %b", t, obs, e);
      end
    end
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] e);
    vectors++;
    assert (dut.frame_cnt_q === e) else begin
      miscompares++;
      $error("FAIL %s: observed frame_cnt=%0d required %0d", tag, dut.frame_cnt_q, e);
    end
  endtask

  initial begin
    // Reset state
    expect_out("reset_state", S_IDLE, 0, 1, 2'b00, 0);
    step(3);
    compare();
    check_cnt("reset_cnt", 8'd0);
    Reset = 1'b0;
    expect_out("idle_hold", S_IDLE, 0, 1, 2'b00, 0);
    step(2);
    compare();

    // Start: one level_reset pulse, key held gives no second pulse
    start_key = 1'b1;
    expect_out("start_pulse", S_PLAY, 1, 0, 2'b00, 0);
    step(1);
    compare();
    expect_out("start_pulse_end", S_PLAY, 0, 0, 2'b00, 0);
    step(1);
    compare();
    expect_out("start_held", S_PLAY, 0, 0, 2'b00, 0);
    step(3);
    compare();
    start_key = 1'b0;
    step(1);

    // Player 2 death, blink cadence, timed exit
    player2_dead = 1'b1;
    expect_out("p2_death", S_DYING, 0, 1, 2'b10, 0);
    step(1);
    compare();
    player2_dead = 1'b0;
    start_key = 1'b1;
    expect_out("dying_ignores_start", S_DYING, 0, 1, 2'b10, 0);
    step(2);
    compare();
    start_key = 1'b0;
    expect_out("blink_8", S_DYING, 0, 1, 2'b10, 1);
    frame_pulses(8);
    compare();
    expect_out("blink_16", S_DYING, 0, 1, 2'b10, 0);
    frame_pulses(8);
    compare();
    expect_out("dying_59", S_DYING, 0, 1, 2'b10, 1);
    frame_pulses(43);
    compare();
    check_cnt("dying_cnt_59", 8'd59);
    expect_out("gameover_60", S_GAMEOVER, 0, 1, 2'b10, 0);
    frame_pulses(1);
    compare();

    // Restart from GAMEOVER clears dead_player
    start_key = 1'b1;
    expect_out("gameover_restart", S_PLAY, 1, 0, 2'b00, 0);
    step(1);
    compare();
    start_key = 1'b0;
    step(1);

    // Death beats win in the same cycle
    player1_dead = 1'b1;
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    expect_out("death_over_win", S_DYING, 0, 1, 2'b01, 0);
    step(1);
    compare();
    player1_dead = 1'b0;
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;

    // Reset mid-DYING
    frame_pulses(30);
    check_cnt("dying_cnt_30", 8'd30);
    Reset = 1'b1;
    expect_out("reset_mid_dying", S_IDLE, 0, 1, 2'b00, 0);
    step(1);
    compare();
    check_cnt("reset_mid_cnt", 8'd0);
    Reset = 1'b0;
    step(1);

    // Win path
    start_key = 1'b1;
    step(1);
    start_key = 1'b0;
    step(1);
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    expect_out("win_entry", S_WIN, 0, 1, 2'b00, 0);
    step(1);
    compare();
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    start_key = 1'b1;
    expect_out("win_ignores_start", S_WIN, 0, 1, 2'b00, 0);
    step(2);
    compare();
    start_key = 1'b0;
    expect_out("win_119", S_WIN, 0, 1, 2'b00, 0);
    frame_pulses(119);
    compare();
    expect_out("win_to_idle", S_IDLE, 0, 1, 2'b00, 0);
    frame_pulses(1);
    compare();

    // GAMEOVER: start edge coincides with timeout, stale death ignored during pulse
    start_key = 1'b1;
    step(1);
    start_key = 1'b0;
    step(1);
    player2_dead = 1'b1;
    step(1);
    player2_dead = 1'b0;
    frame_pulses(60);
    expect_out("gameover_179", S_GAMEOVER, 0, 1, 2'b10, 0);
    frame_pulses(179);
    compare();
    frame_clk = 1'b1;
    player1_dead = 1'b1;
    expect_out("gameover_at_limit", S_GAMEOVER, 0, 1, 2'b10, 0);
    step(3);
    compare();
    check_cnt("gameover_cnt_180", 8'd180);
    start_key = 1'b1;
    expect_out("start_beats_timeout", S_PLAY, 1, 0, 2'b00, 0);
    step(1);
    compare();
    frame_clk = 1'b0;
    expect_out("stale_dead_ignored", S_PLAY, 0, 0, 2'b00, 0);
    step(1);
    compare();
    player1_dead = 1'b0;
    start_key = 1'b0;
    expect_out("play_stays", S_PLAY, 0, 0, 2'b00, 0);
    step(2);
    compare();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
